// File: rtl/sipo_frame_capture.sv
// Frame capture stage behind a SIPO shift register. It counts load strobes,
// snapshots a completed frame one edge after its final bit, and offers it on valid/ready.
`timescale 1ns/1ps

module sipo_frame_capture #(
    parameter int WIDTH = 500
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_i,
    input  logic [WIDTH-1:0]               shift_data_i,
    input  logic                           realign_i,
    output logic [WIDTH-1:0]               out_data_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic                           overrun_o,
    input  logic                           clear_overrun_i,
    output logic [$clog2(WIDTH+1)-1:0]     bit_count_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < 1) begin : g_width_check
        $fatal(1, "sipo_frame_capture: WIDTH must be at least 1");
    end

    logic [CW-1:0]    count_q, count_d;
    logic             pending_q, pending_d;
    (* shreg_extract = "no" *) logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic             drop_s;

    // Bit counter: pending pulses for one cycle after the final bit of a frame.
    always_comb begin
        count_d   = count_q;
        pending_d = 1'b0;
        if (realign_i) begin
            count_d   = '0;
            pending_d = 1'b0;
        end else if (load_i) begin
            if (count_q == LAST_BIT) begin
                count_d   = '0;
                pending_d = 1'b1;
            end else begin
                count_d   = count_q + CW'(1);
                pending_d = 1'b0;
            end
        end else begin
            count_d   = count_q;
            pending_d = 1'b0;
        end
    end

    // Capture/handshake: an unaccepted frame is never overwritten; the new one is dropped.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        drop_s      = 1'b0;
        if (pending_q) begin
            if (!out_valid_q || out_ready_i) begin
                out_data_d  = shift_data_i;
                out_valid_d = 1'b1;
            end else begin
                drop_s      = 1'b1;
            end
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Sticky overrun; a drop on the same edge as a clear keeps it set.
    always_comb begin
        overrun_d = overrun_q;
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (clear_overrun_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            pending_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            pending_q   <= pending_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign overrun_o   = overrun_q;
    assign bit_count_o = count_q;

endmodule

// File: tb/tb_sipo_frame_capture.sv
// Bench for sipo_frame_capture: a WIDTH=8 instance against a frame-level model
// with an upstream shift register, plus a WIDTH=1 instance for the degenerate case.
`timescale 1ns/1ps

module tb_sipo_frame_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       load8, realign8, ready8, clr8, ov8, or8;
    logic [7:0] sd8, od8;
    logic [3:0] bc8;
    logic       load1, realign1, ready1, clr1, v1, or1;
    logic [0:0] sd1, od1, bc1;

    int checks = 0;
    int errors = 0;

    // Reference model: bits seen in current frame, frame-complete flag, output side, upstream register
    int         m_bits;
    bit         m_done;
    bit         m_valid, m_ovr;
    logic [7:0] m_data, m_sreg;

    sipo_frame_capture #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .load_i(load8), .shift_data_i(sd8), .realign_i(realign8),
        .out_data_o(od8), .out_valid_o(ov8), .out_ready_i(ready8), .overrun_o(or8),
        .clear_overrun_i(clr8), .bit_count_o(bc8)
    );

    sipo_frame_capture #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .load_i(load1), .shift_data_i(sd1), .realign_i(realign1),
        .out_data_o(od1), .out_valid_o(v1), .out_ready_i(ready1), .overrun_o(or1),
        .clear_overrun_i(clr1), .bit_count_o(bc1)
    );

    task automatic model_reset();
        m_bits = 0; m_done = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
        m_data = 8'h00; m_sreg = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load8 = 1'b0; realign8 = 1'b0; ready8 = 1'b0; clr8 = 1'b0; sd8 = 8'h00;
        load1 = 1'b0; realign1 = 1'b0; ready1 = 1'b0; clr1 = 1'b0; sd1 = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One clock of the WIDTH=8 instance: drive inputs, advance the model, settle after the edge.
    task automatic step8(input logic l, input logic b, input logic ra, input logic rdy, input logic clr);
        bit dropped;
        load8 = l; realign8 = ra; ready8 = rdy; clr8 = clr;
        dropped = 1'b0;
        if (m_done) begin
            if (!m_valid || rdy) begin
                m_data  = m_sreg;
                m_valid = 1'b1;
            end else begin
                dropped = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_ovr = dropped ? 1'b1 : (clr ? 1'b0 : m_ovr);
        if (ra) begin
            m_bits = 0;
            m_done = 1'b0;
        end else if (l) begin
            m_bits = m_bits + 1;
            m_done = (m_bits == 8);
            if (m_done) m_bits = 0;
        end else begin
            m_done = 1'b0;
        end
        if (l) m_sreg = {m_sreg[6:0], b};
        @(posedge clk); #1;
        sd8 = m_sreg;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bc8 !== 4'd0) begin errors++; $display("FAIL reset_count8 got %0d want 0", bc8); end
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_valid8 got %b want 0", ov8); end
        checks++; if (or8 !== 1'b0) begin errors++; $display("FAIL reset_overrun8 got %b want 0", or8); end
        checks++; if (od8 !== 8'h00) begin errors++; $display("FAIL reset_data8 got %h want 00", od8); end
        checks++; if ({bc1, v1, or1, od1} !== 4'b0000) begin errors++; $display("FAIL reset_w1 got %b want 0000", {bc1, v1, or1, od1}); end
    endtask

    task automatic test_single_frame();
        logic [7:0] pat;
        pat = 8'hB2;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step8(1'b1, pat[7-i], 1'b0, 1'b1, 1'b0);
            checks++; if (bc8 !== 4'((i + 1) % 8)) begin errors++; $display("FAIL t1_count bit %0d got %0d want %0d", i, bc8, (i + 1) % 8); end
            checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL t1_early_valid bit %0d got %b want 0", i, ov8); end
        end
        step8(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL t1_valid got %b want 1", ov8); end
        checks++; if (od8 !== 8'hB2) begin errors++; $display("FAIL t1_data got %h want b2", od8); end
        step8(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL t1_accept got %b want 0", ov8); end
    endtask

    task automatic test_overrun();
        logic [15:0] pat;
        pat = 16'hA53C;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step8(1'b1, pat[15-i], 1'b0, 1'b0, 1'b0);
            if (i >= 8) begin
                checks++; if (od8 !== 8'hA5 || ov8 !== 1'b1) begin errors++; $display("FAIL t2_hold bit %0d got %h/%b want a5/1", i, od8, ov8); end
            end
            checks++; if (or8 !== 1'b0) begin errors++; $display("FAIL t2_early_overrun bit %0d got %b want 0", i, or8); end
        end
        step8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (or8 !== 1'b1) begin errors++; $display("FAIL t2_overrun got %b want 1", or8); end
        checks++; if (od8 !== 8'hA5) begin errors++; $display("FAIL t2_data got %h want a5", od8); end
        step8(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (ov8 !== 1'b0 || or8 !== 1'b1) begin errors++; $display("FAIL t2_accept got %b/%b want 0/1", ov8, or8); end
        step8(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (or8 !== 1'b0) begin errors++; $display("FAIL t2_clear got %b want 0", or8); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pat;
        pat = 16'hA53C;
        do_reset();
        for (int i = 0; i < 16; i++) step8(1'b1, pat[15-i], 1'b0, 1'b0, 1'b0);
        checks++; if (od8 !== 8'hA5) begin errors++; $display("FAIL t3_first got %h want a5", od8); end
        step8(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (od8 !== 8'h3C || ov8 !== 1'b1) begin errors++; $display("FAIL t3_replace got %h/%b want 3c/1", od8, ov8); end
        checks++; if (or8 !== 1'b0) begin errors++; $display("FAIL t3_overrun got %b want 0", or8); end
        step8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (od8 !== 8'h3C || ov8 !== 1'b1) begin errors++; $display("FAIL t3_hold got %h/%b want 3c/1", od8, ov8); end
    endtask

    task automatic test_realign();
        int caps;
        caps = 0;
        do_reset();
        for (int i = 0; i < 5; i++) step8(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        checks++; if (bc8 !== 4'd5) begin errors++; $display("FAIL t4_pre_count got %0d want 5", bc8); end
        step8(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (bc8 !== 4'd0) begin errors++; $display("FAIL t4_realign_count got %0d want 0", bc8); end
        for (int i = 0; i < 9; i++) begin
            step8(i < 8, 1'b1, 1'b0, 1'b1, 1'b0);
            if (ov8 === 1'b1) caps++;
        end
        checks++; if (caps !== 1) begin errors++; $display("FAIL t4_captures got %0d want 1", caps); end
        checks++; if (od8 !== 8'hFF) begin errors++; $display("FAIL t4_data got %h want ff", od8); end
    endtask

    task automatic test_async_reset();
        int caps;
        caps = 0;
        do_reset();
        for (int i = 0; i < 17; i++) step8(i < 16, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step8(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (bc8 !== 4'd6 || ov8 !== 1'b1 || or8 !== 1'b1) begin errors++; $display("FAIL t5_pre got %0d/%b/%b want 6/1/1", bc8, ov8, or8); end
        #3 rst = 1'b1;
        #1;
        checks++; if (bc8 !== 4'd0 || ov8 !== 1'b0 || or8 !== 1'b0) begin errors++; $display("FAIL t5_async got %0d/%b/%b want 0/0/0", bc8, ov8, or8); end
        model_reset();
        load8 = 1'b0; sd8 = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step8(i < 8, 1'b1, 1'b0, 1'b1, 1'b0);
            if (ov8 === 1'b1) caps++;
        end
        checks++; if (caps !== 1) begin errors++; $display("FAIL t5_captures got %0d want 1", caps); end
    endtask

    task automatic test_random();
        logic l, b, ra, rdy, clr;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            l   = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 1) == 0);
            clr = ($urandom_range(0, 19) == 0);
            step8(l, b, ra, rdy, clr);
            checks++;
            if (bc8 !== 4'(m_bits) || ov8 !== m_valid || or8 !== m_ovr || (m_valid && od8 !== m_data)) begin
                errors++;
                $display("FAIL rand cyc %0d got cnt=%0d v=%b ov=%b d=%h want cnt=%0d v=%b ov=%b d=%h",
                         i, bc8, ov8, or8, od8, m_bits, m_valid, m_ovr, m_data);
            end
        end
    endtask

    task automatic test_width1();
        logic [3:0] p1;
        p1 = 4'b1011;
        do_reset();
        ready1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            load1 = (i < 4);
            @(posedge clk); #1;
            if (i < 4) sd1 = p1[3-i];
            checks++; if (bc1 !== 1'b0 || or1 !== 1'b0) begin errors++; $display("FAIL w1_count cyc %0d got %b/%b want 0/0", i, bc1, or1); end
            if (i >= 1 && i <= 4) begin
                checks++; if (v1 !== 1'b1 || od1 !== p1[4-i]) begin errors++; $display("FAIL w1_capture cyc %0d got %b/%b want 1/%b", i, v1, od1, p1[4-i]); end
            end else begin
                checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL w1_idle cyc %0d got %b want 0", i, v1); end
            end
        end
        load1 = 1'b0;
        ready1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overrun();
        test_back_to_back();
        test_realign();
        test_async_reset();
        test_random();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
